// File: rtl/wb_cpu_pkg.sv
// Shared types and constants for the Wishbone CPU initiator.
package wb_cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH1  = 2'd1,
    PH2  = 2'd2
  } state_t;

  localparam int          ADR_W   = 20;
  localparam logic [15:0] TO_FILL = 16'hFFFF;

endpackage

// File: rtl/wb_cpu_init_if.sv
// Single-master Wishbone bus between the CPU initiator and the memory map slave port.
interface wb_cpu_init_if;
  import wb_cpu_pkg::*;

  logic [ADR_W-1:0] wb_adr_o;
  logic [15:0]      wb_dat_o;
  logic [15:0]      wb_dat_i;
  logic             wb_we_o;
  logic             wb_stb_o;
  logic             wb_cyc_o;
  logic             wb_byte_o;
  logic             wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o, wb_byte_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o, wb_byte_o,
    output wb_dat_i, wb_ack_i
  );

endinterface

// File: rtl/wb_cpu_init.sv
// Wishbone initiator for CPU memory requests; odd word accesses become two byte phases.
// Optional ack timeout enabled by defining WB_TIMEOUT_EN (TO_CYCLES per bus phase).
module wb_cpu_init
  import wb_cpu_pkg::*;
#(
  parameter int TO_CYCLES = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cpu_req_i,
  input  logic [ADR_W-1:0] cpu_adr_i,
  input  logic [15:0]      cpu_dat_i,
  input  logic             cpu_we_i,
  input  logic             cpu_byte_i,
  output logic [15:0]      cpu_dat_o,
  output logic             cpu_done_o,
  output logic             cpu_busy_o,
  output logic             cpu_err_o,
  wb_cpu_init_if.master    wb
);

  if (TO_CYCLES < 1 || TO_CYCLES > 65536) begin : g_to_range
    $error("TO_CYCLES must be within 1..65536");
  end

  state_t           state, state_next;
  logic [ADR_W-1:0] bus_adr, bus_adr_next;
  logic [15:0]      bus_dat, bus_dat_next;
  logic             bus_we, bus_we_next;
  logic             bus_stb, bus_stb_next;
  logic             bus_cyc, bus_cyc_next;
  logic             bus_byte, bus_byte_next;
  logic [15:0]      rd_dat, rd_dat_next;
  logic             done, done_next;
  logic             busy, busy_next;
  logic             err, err_next;
  logic             split, split_next;
  logic [7:0]       hi_byte, hi_byte_next;
  logic [7:0]       lo_byte, lo_byte_next;
  logic             timeout;

`ifdef WB_TIMEOUT_EN
  localparam logic [15:0] TO_LOAD = 16'(TO_CYCLES - 1);
  logic [15:0] to_cnt;

  // Reload on every phase entry so the second half of a split gets a full budget.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      to_cnt <= '0;
    else if ((state == IDLE && state_next == PH1) || (state == PH1 && state_next == PH2))
      to_cnt <= TO_LOAD;
    else if (state != IDLE && !wb.wb_ack_i && to_cnt != '0)
      to_cnt <= to_cnt - 16'd1;
  end

  assign timeout = (state != IDLE) && !wb.wb_ack_i && (to_cnt == '0);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      bus_adr  <= '0;
      bus_dat  <= '0;
      bus_we   <= 1'b0;
      bus_stb  <= 1'b0;
      bus_cyc  <= 1'b0;
      bus_byte <= 1'b0;
      rd_dat   <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      split    <= 1'b0;
      hi_byte  <= '0;
      lo_byte  <= '0;
    end else begin
      state    <= state_next;
      bus_adr  <= bus_adr_next;
      bus_dat  <= bus_dat_next;
      bus_we   <= bus_we_next;
      bus_stb  <= bus_stb_next;
      bus_cyc  <= bus_cyc_next;
      bus_byte <= bus_byte_next;
      rd_dat   <= rd_dat_next;
      done     <= done_next;
      busy     <= busy_next;
      err      <= err_next;
      split    <= split_next;
      hi_byte  <= hi_byte_next;
      lo_byte  <= lo_byte_next;
    end
  end

  // The done guard keeps a request held through the completion cycle from being re-accepted.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cpu_req_i && !done) state_next = PH1;
      PH1:     if (wb.wb_ack_i) state_next = split ? PH2 : IDLE;
               else if (timeout) state_next = IDLE;
      PH2:     if (wb.wb_ack_i || timeout) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus_adr_next  = bus_adr;
    bus_dat_next  = bus_dat;
    bus_we_next   = bus_we;
    bus_stb_next  = bus_stb;
    bus_cyc_next  = bus_cyc;
    bus_byte_next = bus_byte;
    rd_dat_next   = rd_dat;
    busy_next     = busy;
    split_next    = split;
    hi_byte_next  = hi_byte;
    lo_byte_next  = lo_byte;
    done_next     = 1'b0;
    err_next      = 1'b0;
    case (state)
      IDLE: if (cpu_req_i && !done) begin
        split_next    = !cpu_byte_i && cpu_adr_i[0];
        bus_adr_next  = cpu_adr_i;
        bus_dat_next  = (cpu_byte_i || cpu_adr_i[0]) ? {8'h00, cpu_dat_i[7:0]} : cpu_dat_i;
        hi_byte_next  = cpu_dat_i[15:8];
        bus_we_next   = cpu_we_i;
        bus_byte_next = cpu_byte_i || cpu_adr_i[0];
        bus_stb_next  = 1'b1;
        bus_cyc_next  = 1'b1;
        busy_next     = 1'b1;
      end
      PH1: if (wb.wb_ack_i) begin
        if (split) begin
          bus_adr_next = bus_adr + 1'b1;
          bus_dat_next = {8'h00, hi_byte};
          lo_byte_next = wb.wb_dat_i[7:0];
        end else begin
          bus_stb_next = 1'b0;
          bus_cyc_next = 1'b0;
          busy_next    = 1'b0;
          done_next    = 1'b1;
          if (!bus_we)
            rd_dat_next = bus_byte ? {8'h00, wb.wb_dat_i[7:0]} : wb.wb_dat_i;
        end
      end else if (timeout) begin
        bus_stb_next = 1'b0;
        bus_cyc_next = 1'b0;
        busy_next    = 1'b0;
        done_next    = 1'b1;
        err_next     = 1'b1;
        rd_dat_next  = TO_FILL;
      end
      PH2: if (wb.wb_ack_i) begin
        bus_stb_next = 1'b0;
        bus_cyc_next = 1'b0;
        busy_next    = 1'b0;
        done_next    = 1'b1;
        if (!bus_we)
          rd_dat_next = {wb.wb_dat_i[7:0], lo_byte};
      end else if (timeout) begin
        bus_stb_next = 1'b0;
        bus_cyc_next = 1'b0;
        busy_next    = 1'b0;
        done_next    = 1'b1;
        err_next     = 1'b1;
        rd_dat_next  = TO_FILL;
      end
      default: begin
        bus_stb_next = 1'b0;
        bus_cyc_next = 1'b0;
        busy_next    = 1'b0;
      end
    endcase
  end

  assign wb.wb_adr_o  = bus_adr;
  assign wb.wb_dat_o  = bus_dat;
  assign wb.wb_we_o   = bus_we;
  assign wb.wb_stb_o  = bus_stb;
  assign wb.wb_cyc_o  = bus_cyc;
  assign wb.wb_byte_o = bus_byte;
  assign cpu_dat_o    = rd_dat;
  assign cpu_done_o   = done;
  assign cpu_busy_o   = busy;
  assign cpu_err_o    = err;

endmodule
